// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped I/O blocks.
package io_pkg;
  localparam int DATA_W = 16;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam logic SEL_SW = 1'b0;
  localparam logic SEL_BTN = 1'b1;
endpackage

// File: rtl/debouncer.sv
// debouncer: single-bit synchronizer, debounce counter and stable level with press pulse.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stab,
  output logic rise
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1_q, sync_q, stab_q, stab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    rise = !stab_q && sync_q && cnt_q == LAST;
    stab_d = (sync_q != stab_q && cnt_q == LAST) ? sync_q : stab_q;
    cnt_d = (sync_q == stab_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      sync_q <= 1'b0;
      stab_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= din;
      sync_q <= s1_q;
      stab_q <= stab_d;
      cnt_q <= cnt_d;
    end
  end
  assign stab = stab_q;
endmodule

// File: rtl/input_controller.sv
// input_controller: switch/button input port with sticky press bits cleared by event-word reads.
module input_controller
  import io_pkg::*;
#(
  parameter int SW_WIDTH = 8,
  parameter int BTN_WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [BTN_WIDTH-1:0] btn,
  input  logic                 re,
  input  logic                 sel,
  output logic [DATA_W-1:0]    out
);
  logic [SW_WIDTH-1:0] sw_s1_q, sw_sync_q;
  logic [BTN_WIDTH-1:0] stab, rise, pend_q, pend_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [7:0] sw_word;
  logic [3:0] stab_w, pend_w;
  logic rd_evt;
  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk), .rst_n(rst_n), .din(btn[i]), .stab(stab[i]), .rise(rise[i])
    );
  end
  always_comb begin
    sw_word = '0;
    sw_word[SW_WIDTH-1:0] = sw_sync_q;
    stab_w = '0;
    stab_w[BTN_WIDTH-1:0] = stab;
    pend_w = '0;
    pend_w[BTN_WIDTH-1:0] = pend_q;
    rd_evt = re && sel == SEL_BTN;
    // a press landing on the clearing read survives to the next read
    pend_d = rd_evt ? rise : pend_q | rise;
    out_d = !re ? out_q : (sel == SEL_SW ? {8'h00, sw_word} : {8'h00, stab_w, pend_w});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_sync_q <= '0;
      pend_q <= '0;
      out_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_sync_q <= sw_s1_q;
      pend_q <= pend_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
endmodule

// File: tb/tb_input_controller.sv
// tb_input_controller: directed vector table plus hand-written reset sequences, DEBOUNCE_CYCLES=4.
module tb_input_controller;
  typedef struct {
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic        re;
    logic        sel;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] sw = '0;
  logic [3:0] btn = '0;
  logic re = 1'b0;
  logic sel = 1'b0;
  logic [15:0] out;
  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  input_controller #(.SW_WIDTH(8), .BTN_WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .re(re), .sel(sel), .out(out)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [15:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h", name, out, exp);
    end
  endtask
  task automatic drive(input logic [7:0] s, input logic [3:0] b, input logic r, input logic l);
    sw = s;
    btn = b;
    re = r;
    sel = l;
  endtask
  initial begin
    // switches, hold, bounce, press timing, read-clear, release, collision
    vq.push_back('{8'hA5, 4'h0, 1'b0, 1'b0, 16'h0000});
    vq.push_back('{8'hA5, 4'h0, 1'b0, 1'b0, 16'h0000});
    vq.push_back('{8'hA5, 4'h0, 1'b0, 1'b0, 16'h0000});
    vq.push_back('{8'hA5, 4'h0, 1'b1, 1'b0, 16'h00A5});
    for (int i = 0; i < 4; i++) vq.push_back('{8'h3C, 4'h0, 1'b0, 1'b0, 16'h00A5});
    vq.push_back('{8'h3C, 4'h1, 1'b0, 1'b0, 16'h00A5});
    vq.push_back('{8'h3C, 4'h0, 1'b0, 1'b0, 16'h00A5});
    vq.push_back('{8'h3C, 4'h1, 1'b0, 1'b0, 16'h00A5});
    for (int i = 0; i < 5; i++) vq.push_back('{8'h3C, 4'h0, 1'b0, 1'b0, 16'h00A5});
    vq.push_back('{8'h3C, 4'h0, 1'b1, 1'b1, 16'h0000});
    for (int i = 0; i < 4; i++) vq.push_back('{8'h3C, 4'h1, 1'b0, 1'b0, 16'h0000});
    vq.push_back('{8'h3C, 4'h1, 1'b1, 1'b1, 16'h0000});
    vq.push_back('{8'h3C, 4'h1, 1'b1, 1'b1, 16'h0000});
    vq.push_back('{8'h3C, 4'h1, 1'b1, 1'b1, 16'h0011});
    vq.push_back('{8'h3C, 4'h1, 1'b1, 1'b1, 16'h0010});
    vq.push_back('{8'h3C, 4'h1, 1'b0, 1'b1, 16'h0010});
    for (int i = 0; i < 6; i++) vq.push_back('{8'h3C, 4'h0, 1'b0, 1'b0, 16'h0010});
    vq.push_back('{8'h3C, 4'h0, 1'b1, 1'b1, 16'h0000});
    vq.push_back('{8'h3C, 4'h0, 1'b1, 1'b1, 16'h0000});
    for (int i = 0; i < 5; i++) vq.push_back('{8'h3C, 4'h4, 1'b0, 1'b0, 16'h0000});
    vq.push_back('{8'h3C, 4'h4, 1'b1, 1'b1, 16'h0000});
    vq.push_back('{8'h3C, 4'h4, 1'b1, 1'b1, 16'h0044});
    vq.push_back('{8'h3C, 4'h4, 1'b1, 1'b1, 16'h0040});
    vq.push_back('{8'h3C, 4'h4, 1'b1, 1'b0, 16'h003C});
    vq.push_back('{8'h00, 4'h4, 1'b0, 1'b0, 16'h003C});
    step(3);
    chk("reset_hold", 16'h0000);
    rst_n = 1'b1;
    step(1);
    chk("after_reset", 16'h0000);
    drive(8'h00, 4'h0, 1'b1, 1'b1);
    step(1);
    chk("first_event_read", 16'h0000);
    drive(8'h00, 4'h0, 1'b0, 1'b0);
    step(1);
    foreach (vq[j]) begin
      drive(vq[j].sw, vq[j].btn, vq[j].re, vq[j].sel);
      step(1);
      checks++;
      if (out !== vq[j].exp) begin
        errors++;
        $display("FAIL vec%0d: out=%h expected=%h", j, out, vq[j].exp);
      end
    end
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 16'h0000);
    step(1);
    rst_n = 1'b1;
    drive(8'h00, 4'h2, 1'b0, 1'b0);
    step(3);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_debounce", 16'h0000);
    step(2);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(8'h00, 4'h2, 1'b0, 1'b0);
      step(1);
    end
    drive(8'h00, 4'h2, 1'b1, 1'b1);
    step(1);
    chk("restart_early", 16'h0000);
    step(1);
    chk("restart_edge", 16'h0000);
    step(1);
    chk("restart_pend", 16'h0022);
    step(1);
    chk("restart_clear", 16'h0020);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
